mmio_uart_tx_ctrl: RTL and testbench

Controller behind the MMIO write port (4KB region, 64-bit words, word address 9 bits). It decodes UART/LED stores and queues UART bytes in a small FIFO. It sequences an 8N1 serial transmitter, with bit timing taken from a software-programmed clock divider. It is write-only: MMIO reads remain unsupported and are not handled here.

---
 rtl/mmio_uart_tx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mmio_uart_tx_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_ctrl.sv
// MMIO write-port controller: decodes UART/LED stores, queues UART bytes in a
// small FIFO and drives an 8N1 transmitter with a software-programmed divider.
module mmio_uart_tx_ctrl #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] DEFAULT_CKDIV = 32'd434,
    parameter logic [31:0] MIN_CKDIV     = 32'd4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [8:0]                    wr_addr,
    input  logic [63:0]                   wr_data,
    input  logic [7:0]                    wr_mask,
    input  logic                          ovf_clr,
    output logic                          uart_txd,
    output logic [7:0]                    leds,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Registers
    logic [31:0]   ckdiv_q, ckdiv_d;
    logic [7:0]    leds_q, leds_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic [1:0]    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   t_q, t_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;

    // Only bytes 0..4 of the data word carry meaning for this block
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[63:40];

    // Store decode; partial lane masks on either half are ignored
    logic wr0, ck_we, push_req, push_ok, drop, led_we, pop;
    assign wr0      = wr_en && (wr_addr == 9'h000);
    assign ck_we    = wr0 && (wr_mask[3:0] == 4'hF);
    assign push_req = wr0 && (wr_mask[7:4] == 4'hF);
    assign led_we   = wr_en && (wr_addr == 9'h001) && wr_mask[0];
    // Full means drop, even if the transmitter pops on the same edge
    assign push_ok  = push_req && !full_q;
    assign drop     = push_req && full_q;

    // Bit time for a frame starting now, floored to keep the counter sane
    logic [31:0] t_new;
    assign t_new = (ckdiv_q < MIN_CKDIV) ? MIN_CKDIV : ckdiv_q;

    logic bit_end, have_byte;
    assign bit_end   = (cnt_q == t_q - 32'd1);
    assign have_byte = (count_q != '0);

    // Config registers, overflow flag and FIFO bookkeeping
    always_comb begin
        ckdiv_d = ck_we  ? wr_data[31:0] : ckdiv_q;
        leds_d  = led_we ? wr_data[7:0]  : leds_q;
        // A fresh drop beats a simultaneous clear
        ovf_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop     ? rptr_q + AW'(1) : rptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    // Transmit sequencer: IDLE -> START -> DATA x8 -> STOP, chaining frames
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (have_byte) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (have_byte) begin
                        pop = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        // Popping always starts a new frame with the line driven low
        if (pop) begin
            sh_d    = mem_q[rptr_q];
            t_d     = t_new;
            cnt_d   = '0;
            txd_d   = 1'b0;
            state_d = S_START;
        end
    end

    // State update; reset abandons any frame and idles the line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckdiv_q <= DEFAULT_CKDIV;
            leds_q  <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_q     <= MIN_CKDIV;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            ckdiv_q <= ckdiv_d;
            leds_q  <= leds_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wr_data[39:32];
    end

    assign uart_txd   = txd_q;
    assign leds       = leds_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx_ctrl.sv
// Directed bench for mmio_uart_tx_ctrl: decode table plus hand-written
// multi-cycle sequences for framing, back-to-back, overflow and reset.
module tb_mmio_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic        ovf_clr = 1'b0;
    logic        uart_txd;
    logic [7:0]  leds;
    logic        tx_busy;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;

    mmio_uart_tx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .ovf_clr(ovf_clr),
        .uart_txd(uart_txd), .leds(leds), .tx_busy(tx_busy),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [8:0]  a;
        logic [63:0] d;
        logic [7:0]  m;
        logic [7:0]  exp_leds;
        logic [2:0]  exp_cnt;
        string       nm;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    endtask

    task automatic idle_wr();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    endtask

    // Called at a negedge; the write lands on the next posedge
    task automatic do_wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        set_wr(a, d, m);
        @(negedge clk);
        idle_wr();
    endtask

    // Entered at the negedge right after the start-bit edge; samples every
    // cycle of all 10 bits and leaves at the negedge after the frame's last edge
    task automatic check_frame(input logic [7:0] b, input int t, input string nm);
        logic [9:0] bits;
        logic       seen;
        logic       busy_ok;
        bits = {1'b1, b, 1'b0};
        busy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            seen = uart_txd;
            for (int k = 0; k < t; k++) begin
                if (uart_txd !== bits[i]) seen = uart_txd;
                if (tx_busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", nm, i), {63'd0, seen}, {63'd0, bits[i]});
        end
        check({nm, "_busy"}, {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        vt[0] = '{9'h001, 64'h5A,                   8'h01, 8'h5A, 3'd0, "led_write"};
        vt[1] = '{9'h001, 64'hFF,                   8'h00, 8'h5A, 3'd0, "led_mask0"};
        vt[2] = '{9'h001, 64'h00,                   8'hFE, 8'h5A, 3'd0, "led_lane0_off"};
        vt[3] = '{9'h002, {24'h0, 8'hA5, 32'd5},    8'hFF, 8'h5A, 3'd0, "addr2_ignored"};
        vt[4] = '{9'h000, {24'h0, 8'h77, 32'd0},    8'h70, 8'h5A, 3'd0, "partial_push"};
        vt[5] = '{9'h000, 64'd5,                    8'h07, 8'h5A, 3'd0, "partial_ckdiv"};
        vt[6] = '{9'h101, 64'h33,                   8'h01, 8'h5A, 3'd0, "addr_hi_ignored"};
        vt[7] = '{9'h001, 64'h1234,                 8'h03, 8'h34, 3'd0, "led_write2"};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_txd", {63'd0, uart_txd}, 64'd1);
        check("rst_busy", {63'd0, tx_busy}, 64'd0);
        check("rst_cnt", {61'd0, fifo_count}, 64'd0);
        check("rst_full", {63'd0, fifo_full}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_leds", {56'd0, leds}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single byte, ckdiv 8 in the same write
        do_wr(9'h000, {24'h0, 8'hA5, 32'd8}, 8'hFF);
        check("t1_txd_E0", {63'd0, uart_txd}, 64'd1);
        check("t1_cnt_E0", {61'd0, fifo_count}, 64'd1);
        @(negedge clk);
        check("t1_txd_E1", {63'd0, uart_txd}, 64'd0);
        check("t1_cnt_E1", {61'd0, fifo_count}, 64'd0);
        check_frame(8'hA5, 8, "t1");
        check("t1_busy_end", {63'd0, tx_busy}, 64'd0);
        check("t1_txd_end", {63'd0, uart_txd}, 64'd1);

        // 2: six pushes into a depth-4 FIFO, back-to-back frames, overflow
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i == 0) set_wr(9'h000, {24'h0, 8'h01, 32'd4}, 8'hFF);
                    else        set_wr(9'h000, {24'h0, 8'(i + 1), 32'd0}, 8'hF0);
                    @(negedge clk);
                    if (i == 4) begin
                        check("t2_full", {63'd0, fifo_full}, 64'd1);
                        check("t2_cnt4", {61'd0, fifo_count}, 64'd4);
                        check("t2_ovf_pre", {63'd0, overflow}, 64'd0);
                    end
                    if (i == 5) begin
                        check("t2_ovf", {63'd0, overflow}, 64'd1);
                        check("t2_cnt_drop", {61'd0, fifo_count}, 64'd4);
                    end
                end
                idle_wr();
            end
            begin
                repeat (2) @(negedge clk);
                for (int b = 1; b <= 5; b++)
                    check_frame(8'(b), 4, $sformatf("t2_f%0d", b));
            end
        join
        check("t2_busy_end", {63'd0, tx_busy}, 64'd0);
        check("t2_cnt_end", {61'd0, fifo_count}, 64'd0);
        check("t2_ovf_sticky", {63'd0, overflow}, 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t2_ovf_clr", {63'd0, overflow}, 64'd0);

        // 3: ckdiv below the floor
        do_wr(9'h000, 64'd2, 8'h0F);
        do_wr(9'h000, {24'h0, 8'hFF, 32'd0}, 8'hF0);
        @(negedge clk);
        check_frame(8'hFF, 4, "t3");
        check("t3_busy_end", {63'd0, tx_busy}, 64'd0);

        // 4: mid-frame ckdiv change only affects the next frame
        fork
            begin
                do_wr(9'h000, {24'h0, 8'h3C, 32'd8}, 8'hFF);
                repeat (20) @(negedge clk);
                do_wr(9'h000, {24'h0, 8'hC3, 32'd16}, 8'hFF);
            end
            begin
                repeat (2) @(negedge clk);
                check_frame(8'h3C, 8, "t4_f1");
                check_frame(8'hC3, 16, "t4_f2");
            end
        join
        check("t4_busy_end", {63'd0, tx_busy}, 64'd0);

        // 5: decode table
        foreach (vt[i]) begin
            do_wr(vt[i].a, vt[i].d, vt[i].m);
            check({vt[i].nm, "_leds"}, {56'd0, leds}, {56'd0, vt[i].exp_leds});
            check({vt[i].nm, "_cnt"}, {61'd0, fifo_count}, {61'd0, vt[i].exp_cnt});
            check({vt[i].nm, "_busy"}, {63'd0, tx_busy}, 64'd0);
        end
        // ckdiv must still be 16 after the partial-mask write
        do_wr(9'h000, {24'h0, 8'h81, 32'd0}, 8'hF0);
        @(negedge clk);
        check_frame(8'h81, 16, "t5_ckdiv");

        // 6: async reset mid-DATA with bytes queued
        do_wr(9'h000, 64'd8, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            set_wr(9'h000, 64'd0, 8'hF0);
            @(negedge clk);
        end
        idle_wr();
        repeat (20) @(negedge clk);
        check("t6_pre_txd", {63'd0, uart_txd}, 64'd0);
        check("t6_pre_cnt", {61'd0, fifo_count}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_txd", {63'd0, uart_txd}, 64'd1);
        check("t6_cnt", {61'd0, fifo_count}, 64'd0);
        check("t6_busy", {63'd0, tx_busy}, 64'd0);
        check("t6_leds", {56'd0, leds}, 64'd0);
        check("t6_full", {63'd0, fifo_full}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic idle_ok;
            idle_ok = 1'b1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (uart_txd !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
            end
            check("t6_idle_after", {63'd0, idle_ok}, 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
